sc_frame_demux: RTL and testbench

Receive-side field demultiplexer for the slow-control link. Accepts the de-stuffed byte stream from the HDLC receiver, steers byte k of each frame into field register k, and checks length (and optionally the FCS). Frame contents are published only on a good frame. It is the counterpart of the transmit-side 22-byte field mux.

---
 rtl/sc_frame_demux.sv | 190 +++++++++++++++++++
 tb/tb_sc_frame_demux.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_frame_demux.sv
// sc_frame_demux: receive-side field demux for the slow-control link.
// Optional FCS check is built when SC_DEMUX_FCS_EN is defined.
module sc_frame_demux #(
  parameter int NUM_BYTES = 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  input  logic                   sof,
  input  logic                   eof,
  input  logic                   abort,
  output logic [8*NUM_BYTES-1:0] frame_bus,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic [1:0]             err_code,
  output logic [4:0]             byte_idx
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } state_t;

  localparam logic [5:0] LAST = 6'(NUM_BYTES - 1);
  localparam logic [5:0] FULL = 6'(NUM_BYTES);

  state_t     state;
  state_t     state_d;
  logic [5:0] idx;
  logic [5:0] idx_d;
  logic [7:0] shadow [NUM_BYTES];
  logic       wr_en;
  logic [5:0] wr_idx;
  logic       good;
  logic       err;
  logic [1:0] code;
  logic       fcs_ok;

`ifdef SC_DEMUX_FCS_EN
  localparam logic [5:0] CRC_END = 6'(NUM_BYTES - 3);

  logic [15:0] crc;
  logic [15:0] crc_d;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic [7:0]  b
  );
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ b[i]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  // FCS bytes arrive as {high, low}; low is on the bus in the eof cycle
  assign fcs_ok = (crc == {shadow[NUM_BYTES-2], byte_in});
`else
  assign fcs_ok = 1'b1;
`endif

  // next-state, write steering and result pulses
  always_comb begin
    state_d = state;
    idx_d   = idx;
    wr_en   = 1'b0;
    wr_idx  = idx;
    good    = 1'b0;
    err     = 1'b0;
    code    = 2'b00;
`ifdef SC_DEMUX_FCS_EN
    crc_d   = crc;
`endif
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (byte_valid) begin
      if (sof) begin
        if (eof) begin
          err     = 1'b1;
          code    = 2'b01;
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          idx_d   = 6'd1;
          state_d = RECV;
`ifdef SC_DEMUX_FCS_EN
          crc_d   = crc_step(16'hFFFF, byte_in);
`endif
        end
      end else begin
        unique case (state)
          RECV: begin
            if (eof) begin
              state_d = IDLE;
              idx_d   = '0;
              if (idx != LAST) begin
                err  = 1'b1;
                code = 2'b01;
              end else if (!fcs_ok) begin
                err  = 1'b1;
                code = 2'b11;
              end else begin
                good = 1'b1;
              end
            end else if (idx == FULL) begin
              err     = 1'b1;
              code    = 2'b10;
              state_d = DROP;
              idx_d   = '0;
            end else begin
              wr_en = 1'b1;
              idx_d = idx + 6'd1;
`ifdef SC_DEMUX_FCS_EN
              if (idx <= CRC_END) begin
                crc_d = crc_step(crc, byte_in);
              end
`endif
            end
          end
          DROP: begin
            if (eof) begin
              state_d = IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // state and byte index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  // shadow capture, publish on good frame, result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_bus   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'b00;
      for (int k = 0; k < NUM_BYTES; k++) begin
        shadow[k] <= 8'h00;
      end
`ifdef SC_DEMUX_FCS_EN
      crc <= 16'hFFFF;
`endif
    end else begin
      frame_valid <= good;
      frame_err   <= err;
      if (err) begin
        err_code <= code;
      end
      if (wr_en) begin
        for (int k = 0; k < NUM_BYTES; k++) begin
          if (wr_idx == 6'(k)) begin
            shadow[k] <= byte_in;
          end
        end
      end
      // last byte is taken straight from the bus in the eof cycle
      if (good) begin
        for (int k = 0; k < NUM_BYTES - 1; k++) begin
          frame_bus[8*k +: 8] <= shadow[k];
        end
        frame_bus[8*(NUM_BYTES-1) +: 8] <= byte_in;
      end
`ifdef SC_DEMUX_FCS_EN
      crc <= crc_d;
`endif
    end
  end

  assign byte_idx = idx[4:0];

endmodule

// File: tb/tb_sc_frame_demux.sv
// tb_sc_frame_demux: directed frames with a pulse scoreboard.
// Honors SC_DEMUX_FCS_EN for the corrupted-frame expectation.
module tb_sc_frame_demux;

  localparam int NB = 22;
  localparam int W  = 8 * NB;

  typedef logic [7:0] frame_t [NB];

  typedef struct {
    int         due;
    bit         good;
    logic [1:0] code;
    logic [W-1:0] bus;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         sof;
  logic         eof;
  logic         abort;
  logic [W-1:0] frame_bus;
  logic         frame_valid;
  logic         frame_err;
  logic [1:0]   err_code;
  logic [4:0]   byte_idx;

  int           cyc = 0;
  int           ncmp = 0;
  int           nerr = 0;
  bit           mon_en = 1'b0;
  exp_t         q[$];
  exp_t         cur;
  logic [W-1:0] good_bus;
  frame_t       fa, fb, fc, fd, fe, ff, fg;

  sc_frame_demux #(.NUM_BYTES(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .sof        (sof),
    .eof        (eof),
    .abort      (abort),
    .frame_bus  (frame_bus),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .byte_idx   (byte_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input frame_t f);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < NB - 2; i++) begin
      c = c ^ {f[i], 8'h00};
      for (int j = 0; j < 8; j++) begin
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
    return c;
  endfunction

  task automatic mk(input logic [7:0] base, output frame_t f);
    logic [15:0] c;
    for (int i = 0; i < NB; i++) f[i] = 8'(base + 8'(i));
    c = crc16(f);
    f[NB-2] = c[15:8];
    f[NB-1] = c[7:0];
  endtask

  function automatic logic [W-1:0] pack(input frame_t f);
    logic [W-1:0] b;
    for (int i = 0; i < NB; i++) b[8*i +: 8] = f[i];
    return b;
  endfunction

  task automatic send(input logic [7:0] b, input bit s, input bit e);
    byte_in    = b;
    byte_valid = 1'b1;
    sof        = s;
    eof        = e;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    sof        = 1'b0;
    eof        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input bit g, input logic [1:0] c,
                           input logic [W-1:0] b);
    exp_t e;
    e.due  = cyc + 1;
    e.good = g;
    e.code = c;
    e.bus  = b;
    q.push_back(e);
  endtask

  task automatic send_frame(input frame_t f, input int gap, input bit g,
                            input logic [1:0] c, input logic [W-1:0] b);
    for (int k = 0; k < NB; k++) begin
      if (k == NB - 1) expect_ev(g, c, b);
      send(f[k], k == 0, k == NB - 1);
      if (gap > 0 && k % gap == gap - 1 && k != NB - 1) idle(1);
    end
  endtask

  // scoreboard: every cycle is either the expected pulse or silence
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].due <= cyc) begin
        cur = q.pop_front();
        chk("due_cycle", W'(cyc), W'(cur.due));
        chk("frame_valid", W'(frame_valid), W'(cur.good));
        chk("frame_err", W'(frame_err), W'(!cur.good));
        if (!cur.good) chk("err_code", W'(err_code), W'(cur.code));
        chk("frame_bus", frame_bus, cur.bus);
      end else begin
        chk("no_pulse", W'({frame_valid, frame_err}), '0);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    sof        = 1'b0;
    eof        = 1'b0;
    abort      = 1'b0;
    good_bus   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_bus", frame_bus, '0);
    chk("rst_valid", W'(frame_valid), '0);
    chk("rst_err", W'(frame_err), '0);
    chk("rst_code", W'(err_code), '0);
    chk("rst_idx", W'(byte_idx), '0);
    mon_en = 1'b1;

    mk(8'h00, fa);
    send_frame(fa, 0, 1'b1, 2'b00, pack(fa));
    good_bus = pack(fa);
    chk("good_idx", W'(byte_idx), '0);
    chk("good_f5", W'(frame_bus[47:40]), W'(8'h05));
    chk("good_f19", W'(frame_bus[159:152]), W'(8'h13));

    for (int k = 0; k < 10; k++) begin
      if (k == 9) expect_ev(1'b0, 2'b01, good_bus);
      send(8'(8'h30 + 8'(k)), k == 0, k == 9);
    end
    chk("short_idx", W'(byte_idx), '0);

    for (int k = 0; k < 23; k++) begin
      if (k == 22) expect_ev(1'b0, 2'b10, good_bus);
      send(8'(8'h60 + 8'(k)), k == 0, 1'b0);
    end
    send(8'h91, 1'b0, 1'b0);
    send(8'h92, 1'b0, 1'b1);
    send(8'h93, 1'b0, 1'b1);
    idle(2);
    chk("drop_bus", frame_bus, good_bus);

    mk(8'h80, fb);
    send_frame(fb, 5, 1'b1, 2'b00, pack(fb));
    good_bus = pack(fb);

    mk(8'h00, ff);
    ff[5] = 8'hA5;
`ifdef SC_DEMUX_FCS_EN
    send_frame(ff, 0, 1'b0, 2'b11, good_bus);
    chk("fcs_f5", W'(frame_bus[47:40]), W'(8'h85));
`else
    send_frame(ff, 0, 1'b1, 2'b00, pack(ff));
    good_bus = pack(ff);
    chk("fcs_f5", W'(frame_bus[47:40]), W'(8'hA5));
`endif

    mk(8'h20, fc);
    for (int k = 0; k < 12; k++) send(fc[k], k == 0, 1'b0);
    chk("mid_idx", W'(byte_idx), W'(5'd12));
    abort      = 1'b1;
    byte_valid = 1'b1;
    byte_in    = fc[12];
    @(posedge clk);
    #1;
    abort      = 1'b0;
    byte_valid = 1'b0;
    chk("abort_idx", W'(byte_idx), '0);
    chk("abort_bus", frame_bus, good_bus);
    send(8'h55, 1'b0, 1'b1);
    chk("idle_ign_idx", W'(byte_idx), '0);

    mk(8'hC0, fd);
    for (int k = 0; k < 7; k++) send(8'(8'h10 + 8'(k)), k == 0, 1'b0);
    send_frame(fd, 0, 1'b1, 2'b00, pack(fd));
    good_bus = pack(fd);
    chk("restart_f0", W'(frame_bus[7:0]), W'(8'hC0));

    expect_ev(1'b0, 2'b01, good_bus);
    send(8'h77, 1'b1, 1'b1);
    idle(3);
    chk("code_hold", W'(err_code), W'(2'b01));

    mk(8'hE0, fe);
    for (int k = 0; k < 14; k++) send(fe[k], k == 0, 1'b0);
    rst = 1'b1;
    send(fe[14], 1'b0, 1'b0);
    rst = 1'b0;
    good_bus = '0;
    chk("mrst_bus", frame_bus, '0);
    chk("mrst_code", W'(err_code), '0);
    chk("mrst_idx", W'(byte_idx), '0);
    chk("mrst_pulse", W'({frame_valid, frame_err}), '0);
    for (int k = 15; k < NB; k++) send(fe[k], 1'b0, k == NB - 1);
    chk("post_rst_idx", W'(byte_idx), '0);
    chk("post_rst_bus", frame_bus, '0);

    mk(8'h01, fg);
    send_frame(fg, 3, 1'b1, 2'b00, pack(fg));
    idle(4);
    chk("queue_empty", W'(q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
